// File: rtl/imem_loader.sv
// Boot loader: assembles little-endian N-bit words from a byte stream and writes them
// sequentially into instruction memory, holding the CPU in reset until done.
// Optional trailing-checksum verification: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int N      = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [N-1:0]      wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_hold,
    output logic              err
);

    localparam int NB    = N / 8;
    localparam int BI_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [BI_W-1:0]  LAST_BYTE = BI_W'(NB - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   widx_q, widx_d;
    logic [BI_W-1:0]     bidx_q, bidx_d;
    logic                in_ready_q, in_ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [N-1:0]        wdata_q, wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cpu_hold_q, cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [N-1:0]        xor_q, xor_d;
    logic [N-1:0]        chk_q, chk_d;
    logic                err_q, err_d;
`endif

    logic [CNT_W-1:0]    cnt_sat;
    logic                hs;
    logic                last_word;
    int                  boff;

    assign cnt_sat   = (word_count > MAX_CNT) ? MAX_CNT : word_count;
    assign hs        = in_valid && in_ready_q;
    // cnt_q is 1..2^ADDR_W while loading, so cnt_q-1 always fits the word index
    assign last_word = ({1'b0, widx_q} == (cnt_q - CNT_W'(1)));
    assign boff      = 8 * int'(bidx_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        widx_d     = widx_q;
        bidx_d     = bidx_q;
        in_ready_d = in_ready_q;
        we_d       = we_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        done_d     = done_q;
        cpu_hold_d = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_d      = xor_q;
        chk_d      = chk_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    cnt_d      = cnt_sat;
                    widx_d     = '0;
                    bidx_d     = '0;
                    done_d     = 1'b0;
                    cpu_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_d      = '0;
                    err_d      = 1'b0;
`endif
                    if (cnt_sat == '0) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        cpu_hold_d = 1'b0;
                    end else begin
                        state_d    = S_LOAD;
                        in_ready_d = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (hs) begin
                    wdata_d[boff +: 8] = in_data;
                    if (bidx_q == LAST_BYTE) begin
                        bidx_d     = '0;
                        state_d    = S_WRITE;
                        in_ready_d = 1'b0;
                        we_d       = 1'b1;
                        waddr_d    = widx_q;
                    end else begin
                        bidx_d = bidx_q + BI_W'(1);
                    end
                end
            end
            S_WRITE: begin
                we_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                xor_d = xor_q ^ wdata_q;
`endif
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d    = S_CHECK;
                    in_ready_d = 1'b1;
                    chk_d      = '0;
`else
                    state_d    = S_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
`endif
                end else begin
                    widx_d     = widx_q + ADDR_W'(1);
                    state_d    = S_LOAD;
                    in_ready_d = 1'b1;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                // trailing word is compared only, never written to memory
                if (hs) begin
                    chk_d[boff +: 8] = in_data;
                    if (bidx_q == LAST_BYTE) begin
                        bidx_d     = '0;
                        state_d    = S_DONE;
                        in_ready_d = 1'b0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        err_d      = (chk_d != xor_q);
                        cpu_hold_d = (chk_d != xor_q);
                    end else begin
                        bidx_d = bidx_q + BI_W'(1);
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            widx_q     <= '0;
            bidx_q     <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cpu_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= '0;
            chk_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            widx_q     <= widx_d;
            bidx_q     <= bidx_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cpu_hold_q <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
            chk_q      <= chk_d;
            err_q      <= err_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign cpu_hold = cpu_hold_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule
